// File: rtl/triangular_decomposer_if.sv
// Request/result bundle for the triangular decomposer.
// The requester owns start/sum_in; the decomposer owns status and results.
interface triangular_decomposer_if #(
   parameter int SUM_W = 7,
   parameter int N_W   = 4
);
   logic             start;
   logic [SUM_W-1:0] sum_in;
   logic             busy;
   logic             done;
   logic [N_W-1:0]   n_out;
   logic [SUM_W-1:0] rem_out;
   logic             exact;

   modport master (
      output start, sum_in,
      input  busy, done, n_out, rem_out, exact
   );

   modport slave (
      input  start, sum_in,
      output busy, done, n_out, rem_out, exact
   );
endinterface

// File: rtl/triangular_decomposer.sv
// Recovers the largest n with n(n+1)/2 <= S by subtracting 1, 2, 3, ...
// one term per clock; reports n, the remainder and whether S was triangular.
module triangular_decomposer #(
   parameter int SUM_W = 7,
   parameter int N_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   triangular_decomposer_if.slave bus
);

   localparam int CMP_W = (SUM_W > N_W + 1) ? SUM_W : N_W + 1;
   localparam logic [N_W:0] MAX_K = (N_W + 1)'((2 ** N_W) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [SUM_W-1:0] acc_reg;
   logic [N_W:0]     k_reg;      // one bit wider so it can reach 2^N_W without wrapping
   logic [N_W-1:0]   n_reg;
   logic             exact_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [CMP_W-1:0] acc_ext;
   logic [CMP_W-1:0] k_ext;
   logic [SUM_W-1:0] sub_val;
   logic             can_sub;

   always_comb begin
      acc_ext = CMP_W'(acc_reg);
      k_ext   = CMP_W'(k_reg);
      sub_val = acc_reg - SUM_W'(k_reg);
      can_sub = (acc_ext >= k_ext) && (k_reg <= MAX_K);
   end

   // n and the remainder are shown live while running, so they hold the
   // final result as soon as the failing compare is reached.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         k_reg     <= (N_W + 1)'(1);
         n_reg     <= '0;
         exact_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  acc_reg   <= bus.sum_in;
                  k_reg     <= (N_W + 1)'(1);
                  n_reg     <= '0;
                  exact_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (can_sub) begin
                  acc_reg <= sub_val;
                  n_reg   <= k_reg[N_W-1:0];
                  k_reg   <= k_reg + (N_W + 1)'(1);
               end else begin
                  exact_reg <= (acc_reg == '0);
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_reg;
   assign bus.done    = done_reg;
   assign bus.n_out   = n_reg;
   assign bus.rem_out = acc_reg;
   assign bus.exact   = exact_reg;

endmodule
